mem_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares the single-port SISC main memory

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the shared-memory arbiter.
// master = requesters plus memory model, slave = arbiter.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin fetch/data arbiter for single-port memory; ack MEM_LAT+2 cycles after req.
// Losing requester holds req until served; one access in flight at a time.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst_f,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_FETCH, G_DATA} grant_t;

  state_t     state;
  grant_t     grant;
  logic       rr_ptr;   // 0 = fetch preferred, 1 = data preferred
  logic       g_we;
  logic [3:0] cnt;
  logic       pick_data;

  assign pick_data = bus.d_req && (!bus.if_req || rr_ptr);

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state         <= IDLE;
      grant         <= G_NONE;
      rr_ptr        <= 1'b0;
      g_we          <= 1'b0;
      cnt           <= '0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            // Strobe is registered here so it is high for exactly the ISSUE cycle.
            state        <= ISSUE;
            bus.busy     <= 1'b1;
            bus.mem_en   <= 1'b1;
            grant        <= pick_data ? G_DATA : G_FETCH;
            g_we         <= pick_data && bus.d_we;
            bus.mem_we   <= pick_data && bus.d_we;
            bus.mem_addr <= pick_data ? bus.d_addr : bus.if_addr;
            if (pick_data && bus.d_we)
              bus.mem_wdata <= bus.d_wdata;
          end
        end
        ISSUE: begin
          cnt   <= 4'(MEM_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            if (grant == G_DATA) begin
              bus.d_ack <= 1'b1;
              if (!g_we)
                bus.d_rdata <= bus.mem_rdata;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          rr_ptr   <= ~rr_ptr;
          grant    <= G_NONE;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected accesses, plus MEM_LAT sweep.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_f;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) b15 ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2))  dut (.clk(clk), .rst_f(rst_f), .bus(bus));
  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1))  u1  (.clk(clk), .rst_f(rst_f), .bus(b1));
  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(15)) u15 (.clk(clk), .rst_f(rst_f), .bus(b15));

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: mem_val = 32'hA5A5_0001;
      16'h0200: mem_val = 32'h1234_5678;
      default:  mem_val = {16'hC0DE, a};
    endcase
  endfunction

  // Memory models: read data appears LAT cycles after the strobe cycle.
  logic [31:0] p2 [2];
  logic [31:0] p1;
  logic [31:0] p15 [15];
  always @(posedge clk) begin
    p2[0] <= mem_val(bus.mem_addr);
    p2[1] <= p2[0];
    p1    <= mem_val(b1.mem_addr);
    p15[0] <= mem_val(b15.mem_addr);
    for (int i = 1; i < 15; i++) p15[i] <= p15[i-1];
  end
  assign bus.mem_rdata = p2[1];
  assign b1.mem_rdata  = p1;
  assign b15.mem_rdata = p15[14];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int en_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    logic        data;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  logic [31:0] m_if, m_d;

  task automatic push(input logic data, input logic we, input logic [15:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.data = data; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Monitor on the LAT=2 instance: strobe contents, ack ordering, rdata registers.
  always @(negedge clk) begin
    exp_t e;
    if (rst_f) begin
      if (bus.mem_en) begin
        en_cyc = cyc;
        if (sb.size() == 0) check("mem_en_unexpected", bus.mem_en, 0);
        else begin
          e = sb[0];
          check("mem_we", bus.mem_we, e.data && e.we);
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_wdata", bus.mem_wdata, (e.data && e.we) ? e.wdata : 32'h0);
        end
      end
      if (bus.if_ack || bus.d_ack) begin
        check("ack_exclusive", bus.if_ack & bus.d_ack, 0);
        if (sb.size() == 0) check("ack_unexpected", {bus.if_ack, bus.d_ack}, 0);
        else begin
          e = sb.pop_front();
          check("ack_port", bus.d_ack, e.data);
          check("ack_after_en", cyc - en_cyc, 3);
          if (!e.data) m_if = e.rdata;
          else if (!e.we) m_d = e.rdata;
          check("if_rdata", bus.if_rdata, m_if);
          check("d_rdata", bus.d_rdata, m_d);
        end
      end
    end
  end

  // Each requester task starts #1 after a posedge and ends #1 after a posedge.
  task automatic fetch(input logic [15:0] a, output int n);
    bus.if_addr = a;
    bus.if_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!bus.if_ack && n < 40);
    check("fetch_ack_seen", bus.if_ack, 1);
    @(posedge clk); #1 bus.if_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [15:0] a, input logic [31:0] wd, output int n);
    bus.d_we = we;
    bus.d_addr = a;
    bus.d_wdata = wd;
    bus.d_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!bus.d_ack && n < 40);
    check("data_ack_seen", bus.d_ack, 1);
    @(posedge clk); #1 bus.d_req = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_f = 1'b0;
    @(posedge clk); #1;
    rst_f = 1'b1;
    m_if = '0; m_d = '0;
  endtask

  initial begin
    int n, nf, nd, k;
    logic d1, d15;
    rst_f = 1'b0;
    m_if = '0; m_d = '0;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    b1.if_req = 0;  b1.if_addr = '0;  b1.d_req = 0;  b1.d_we = 0;  b1.d_addr = '0;  b1.d_wdata = '0;
    b15.if_req = 0; b15.if_addr = '0; b15.d_req = 0; b15.d_we = 0; b15.d_addr = '0; b15.d_wdata = '0;

    // Reset held with both requests high
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    bus.if_addr = 16'h0ABC; bus.d_addr = 16'h0DEF; bus.d_we = 1'b1; bus.d_wdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_ctl", {bus.if_ack, bus.d_ack, bus.mem_en, bus.mem_we, bus.busy}, 0);
      check("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
      check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(posedge clk); #1 rst_f = 1'b1;

    // Single fetch
    push(0, 0, 16'h0010, 0, 32'hA5A5_0001);
    fetch(16'h0010, n);
    check("fetch_latency", n, 4);

    // Store leaves d_rdata untouched
    push(1, 1, 16'h0100, 32'hDEAD_BEEF, 0);
    dacc(1, 16'h0100, 32'hDEAD_BEEF, n);
    check("store_latency", n, 4);

    // Contention right after reset: fetch first
    pulse_reset();
    push(0, 0, 16'h0020, 0, mem_val(16'h0020));
    push(1, 0, 16'h0030, 0, mem_val(16'h0030));
    fork
      fetch(16'h0020, nf);
      dacc(0, 16'h0030, 0, nd);
    join
    check("pair1_fetch_cyc", nf, 4);
    check("pair1_data_cyc", nd, 9);

    // Lone fetch moves the pointer to data, so the next pair goes data first
    push(0, 0, 16'h0040, 0, mem_val(16'h0040));
    fetch(16'h0040, n);
    check("lone_fetch_cyc", n, 4);
    push(1, 0, 16'h0050, 0, mem_val(16'h0050));
    push(0, 0, 16'h0060, 0, mem_val(16'h0060));
    fork
      fetch(16'h0060, nf);
      dacc(0, 16'h0050, 0, nd);
    join
    check("pair2_data_cyc", nd, 4);
    check("pair2_fetch_cyc", nf, 9);

    // Load; if_rdata must hold
    push(1, 0, 16'h0200, 0, 32'h1234_5678);
    dacc(0, 16'h0200, 0, n);
    check("load_latency", n, 4);

    // Reset during WAIT aborts the load
    push(1, 0, 16'h0300, 0, mem_val(16'h0300));
    bus.d_we = 1'b0; bus.d_addr = 16'h0300; bus.d_req = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_f = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", bus.busy, 1);
    @(posedge clk); @(negedge clk);
    check("abort_ctl", {bus.if_ack, bus.d_ack, bus.mem_en, bus.busy}, 0);
    check("abort_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    sb.delete();
    m_if = '0; m_d = '0;
    bus.d_req = 1'b0;
    @(posedge clk); #1 rst_f = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_ack", {bus.if_ack, bus.d_ack, bus.busy}, 0);
    end
    @(posedge clk); #1;
    push(1, 0, 16'h0300, 0, mem_val(16'h0300));
    dacc(0, 16'h0300, 0, n);
    check("post_abort_latency", n, 4);

    // MEM_LAT sweep on the other two instances
    b1.if_addr = 16'h0070; b15.if_addr = 16'h0080;
    b1.if_req = 1'b1; b15.if_req = 1'b1;
    d1 = 1'b0; d15 = 1'b0; k = 0;
    while (!(d1 && d15) && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (d1) b1.if_req = 1'b0;
      if (d15) b15.if_req = 1'b0;
      @(negedge clk);
      if (b1.if_ack) begin
        d1 = 1'b1;
        check("lat1_ack_cyc", k, 3);
        check("lat1_rdata", b1.if_rdata, mem_val(16'h0070));
      end
      if (b15.if_ack) begin
        d15 = 1'b1;
        check("lat15_ack_cyc", k, 17);
        check("lat15_rdata", b15.if_rdata, mem_val(16'h0080));
      end
    end
    check("lat1_done", d1, 1);
    check("lat15_done", d15, 1);
    @(posedge clk); #1;
    b1.if_req = 1'b0; b15.if_req = 1'b0;

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
